// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: grant state encoding,
// port identifiers and the memory line width.
package mem_arb_pkg;

    // Width of one off-chip memory line in bits
    localparam int LINE_W = 256;

    // Port identifiers as stored in the "last served" register
    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    // Arbiter states: idle, or memory owned by port 0 / port 1
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arbState_t;

    // Maps a port identifier onto the state that grants it
    function automatic arbState_t grantOf(input logic port);
        return (port == PORT_DC) ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide data memory between the
// instruction-cache refill port (port 0) and the data-cache port (port 1).
// A grant is held until the memory acknowledges or the requester aborts,
// and every transaction is followed by one idle cycle with the memory
// request low so the memory model always sees a fresh request edge.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = LINE_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arbState_t r_state;
    arbState_t w_nextState;
    logic      r_last;
    logic      w_nextLast;

    // State and last-served port register; reset makes port 0 win first contention
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_last  <= PORT_DC;
        end else begin
            r_state <= w_nextState;
            r_last  <= w_nextLast;
        end
    end

    // Next-state logic: round-robin pick in IDLE, release on ack or abort
    always_comb begin
        w_nextState = r_state;
        w_nextLast  = r_last;
        case (r_state)
            IDLE: begin
                if (p0_enable_i && p1_enable_i) begin
                    w_nextState = grantOf(~r_last);
                end else if (p0_enable_i) begin
                    w_nextState = GRANT0;
                end else if (p1_enable_i) begin
                    w_nextState = GRANT1;
                end
            end
            GRANT0: begin
                if (mem_ack_i) begin
                    w_nextState = IDLE;
                    w_nextLast  = PORT_IC;
                end else if (!p0_enable_i) begin
                    w_nextState = IDLE;
                end
            end
            GRANT1: begin
                if (mem_ack_i) begin
                    w_nextState = IDLE;
                    w_nextLast  = PORT_DC;
                end else if (!p1_enable_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Memory-side mux and per-port acks; IDLE parks the mux on port 0 with the request low
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = p0_addr_i;
        mem_data_o   = p0_data_i;
        p0_ack_o     = 1'b0;
        p1_ack_o     = 1'b0;
        case (r_state)
            GRANT0: begin
                mem_enable_o = p0_enable_i;
                mem_write_o  = p0_write_i;
                p0_ack_o     = mem_ack_i;
            end
            GRANT1: begin
                mem_enable_o = p1_enable_i;
                mem_write_o  = p1_write_i;
                mem_addr_o   = p1_addr_i;
                mem_data_o   = p1_data_i;
                p1_ack_o     = mem_ack_i;
            end
            default: begin
                mem_enable_o = 1'b0;
            end
        endcase
    end

    // Read data goes to both ports; only the ack tells a port the data is its own
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 256-bit off-chip data memory between the instruction-cache refill port (port 0) and the data-cache miss/write-back port (port 1). It sits between both caches' memory interfaces and the data memory model. It grants one requester at a time and holds the grant until the memory acknowledges. Grants alternate round-robin when both ports wait, so neither cache starves during back-to-back misses.

## Interface
- DATA_W, 256, memory line width in bits
- ADDR_W, 32, byte address width
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset; one clock; reset is synchronous and active-high
- p0_enable_i  input  1  port 0 request, held high until p0_ack_o
- p0_write_i  input  1  port 0: 1 = line write, 0 = line read
- p0_addr_i  input  ADDR_W  port 0 line address, bits [4:0] zero
- p0_data_i  input  DATA_W  port 0 write data
- p0_data_o  output  DATA_W  read data to port 0
- p0_ack_o  output  1  port 0 transfer complete
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as port 0, for port 1
- mem_enable_o  output  1  memory request, level, held until mem_ack_i
- mem_write_o  output  1  memory write select
- mem_addr_o  output  ADDR_W  memory line address
- mem_data_o  output  DATA_W  memory write data
- mem_data_i  input  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  input  1  memory completion, one-cycle pulse

## Operation
- States: IDLE, GRANT0, GRANT1. Register `last` holds the port most recently served.
- IDLE:
  - Neither request: stay in IDLE.
  - Exactly one port requests: go to that port's GRANT state.
  - Both ports request: grant the port that is not `last`.
- GRANTn:
  - mem_enable_o = pn_enable_i. mem_write_o, mem_addr_o and mem_data_o are muxed from port n.
  - On mem_ack_i: assert pn_ack_o in the same cycle, set `last` = n, go to IDLE.
  - If pn_enable_i drops without an ack (requester abort): go to IDLE and leave `last` unchanged.
- IDLE forces mem_enable_o = 0 and mem_write_o = 0. mem_addr_o and mem_data_o hold their port 0 mux values.
- p0_data_o and p1_data_o both carry mem_data_i unconditionally. Only the ack distinguishes the owner.
- pn_ack_o = mem_ack_i & (state == GRANTn). An ack arriving in IDLE is ignored and leaves state unchanged.
- A write back followed by a refill from the same port is two separate grants. The other port may win between them.
- Reset values: state IDLE, `last` = 1 (port 0 wins the first contention), mem_enable_o 0, mem_write_o 0, p0_ack_o 0, p1_ack_o 0.

## Timing
- Request high in IDLE at edge t: grant registered at t, and mem_enable_o is high in cycle t+1.
- Minimum grant latency is 1 cycle. The arbiter adds no latency on the ack or data path, which are combinational.
- Ack in cycle a: pn_ack_o high in cycle a. State is IDLE in cycle a+1 with mem_enable_o low for that whole cycle. The next grant drives memory from cycle a+2.
  - This guarantees a one-cycle gap with mem_enable_o low between transactions, so the memory model sees a fresh request.
- Simultaneous requests in IDLE: the round-robin pick is decided at the same edge. No combinational loop from pn_enable_i to the grant register.
- Reset mid-transaction:
  - State goes to IDLE at the next edge and mem_enable_o drops.
  - An ack arriving later is ignored.
  - Caches are reset by the same rst_i.

## Structure
- Shared package mem_arb_pkg:
  - state encoding (IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2)
  - port ID constants PORT_IC = 0, PORT_DC = 1
  - LINE_W = 256
- One registered always block for state and `last`. Combinational output mux.
- No sub-module. The round-robin pick is two gates and is inlined.

## Test plan
- Single read, port 1 only:
  - Stimulus: p1_enable_i = 1, write 0, addr 0x0000_0400. Memory acks 10 cycles after mem_enable_o rises with data 0xA5…A5.
  - Required: mem_addr_o = 0x400; p1_ack_o pulses once with p1_data_o = 0xA5…A5; p0_ack_o stays 0.
- Contention after reset:
  - Stimulus: both ports raise enable in the same cycle.
  - Required: port 0 is granted first. Port 1 gets mem_enable_o two cycles after port 0's ack. mem_enable_o is low for exactly 1 cycle in between.
- Fairness:
  - Stimulus: both ports hold enable continuously for 6 transactions.
  - Required: grants alternate 0,1,0,1,0,1.
- Dirty miss sequence:
  - Stimulus: port 1 issues a write to 0x0000_0800 (write 1, data 0x5A…5A), then immediately a read to 0x0000_0C00. Port 0 requests during the write.
  - Required: order is p1 write, then p0 read, then p1 read. mem_write_o = 1 only during the p1 write grant.
- Abort and stray ack:
  - Stimulus: p0 is granted, then drops enable with no ack; memory then pulses mem_ack_i in IDLE.
  - Required: IDLE the cycle after the drop; no pn_ack_o; `last` unchanged.
- Reset mid-grant:
  - Stimulus: assert rst_i while GRANT1 is waiting.
  - Required: mem_enable_o = 0 the cycle after the reset edge. The next contention grants port 0.
